// File: rtl/dataflow_pkg.sv
// Shared helpers for the dataflow stop/valid token interface.
// A token is W data bits with the valid flag sitting directly above them.
package dataflow_pkg;

  function automatic int token_w(input int w);
    return w + 1;
  endfunction

  // Valid flag position inside a token of W data bits.
  function automatic int valid_bit(input int w);
    return w;
  endfunction

  // Pointer width that never collapses to zero bits for single-entry stores.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/inbuf_fifo_if.sv
// Token channel bundle for inbuf_fifo: upstream token/stop, core token/stop
// and occupancy status. The master side is the upstream producer plus core.
interface inbuf_fifo_if #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) ();
  import dataflow_pkg::*;

  localparam int TW = token_w(W);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0] in_data;
  logic          back_stop;
  logic [TW-1:0] core_data;
  logic          core_stop;
  logic [CW-1:0] count;
  logic          almost_full;

  modport master (
    output in_data,
    output core_stop,
    input  back_stop,
    input  core_data,
    input  count,
    input  almost_full
  );

  modport slave (
    input  in_data,
    input  core_stop,
    output back_stop,
    output core_data,
    output count,
    output almost_full
  );

endinterface

// File: rtl/inbuf_store.sv
// DEPTH x W token payload storage: synchronous write, asynchronous read.
// Data is not reset; occupancy tracking in the parent decides what is live.
module inbuf_store
  import dataflow_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [clog2_min1(DEPTH)-1:0] wr_ptr_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic [clog2_min1(DEPTH)-1:0] rd_ptr_i,
  output logic [W-1:0]                 rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: one entry per cycle at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/inbuf_fifo.sv
// Multi-entry input buffer for the stop/valid token interface. Absorbs up to
// DEPTH tokens while the core stalls, reports occupancy, and can optionally
// forward tokens combinationally when empty (BYPASS=1).
module inbuf_fifo
  import dataflow_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 2,
  parameter int BYPASS   = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  inbuf_fifo_if.slave bus
);

  localparam int TW        = token_w(W);
  localparam int VALID_BIT = valid_bit(W);
  localparam int PW        = clog2_min1(DEPTH);
  localparam int CW        = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
    $error("inbuf_fifo: DEPTH must be within 1..64");
  end

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rd_data;
  logic [TW-1:0] core_data;
  logic          full;
  logic          empty;
  logic          bypass_path;
  logic          in_fire;
  logic          out_fire;
  logic          pass_thru;
  logic          push;
  logic          pop;

  // Advance a pointer with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign bypass_path = (BYPASS != 0) && empty;

  // Core-side token: bypassed input when empty in bypass mode, else the head entry.
  always_comb begin
    core_data = '0;
    if (bypass_path) begin
      core_data = bus.in_data;
    end else if (!empty) begin
      core_data = {1'b1, rd_data};
    end
  end

  assign in_fire   = bus.in_data[VALID_BIT] & ~full;
  assign out_fire  = core_data[VALID_BIT] & ~bus.core_stop;
  // A bypassed token consumed by the core in the same cycle never touches storage.
  assign pass_thru = bypass_path & in_fire & out_fire;
  assign push      = in_fire & ~pass_thru;
  assign pop       = out_fire & ~empty;

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset discards every stored token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  inbuf_store #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_store (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (bus.in_data[W-1:0]),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign bus.core_data   = core_data;
  assign bus.back_stop   = full;
  assign bus.count       = count_q;
  assign bus.almost_full = (int'(count_q) >= AF_LEVEL);

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full)
  );

  a_no_pop_when_empty : assert property (
    @(posedge clk) disable iff (!rst_n) !(out_fire && empty && !bypass_path)
  );

  a_count_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) (count_q <= CW'(DEPTH))
  );

endmodule

// File: tb/tb_inbuf_fifo.sv
// Scoreboard bench for inbuf_fifo: directed scenarios on DEPTH=4 instances
// (bypass and registered) plus randomised traffic on DEPTH 1/2/3/5 in both modes.
module tb_inbuf_fifo;
  import dataflow_pkg::*;

  localparam int RCYC = 10000;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rand_go = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed instances
  inbuf_fifo_if #(.W(8), .DEPTH(4)) a_bus ();
  inbuf_fifo #(.W(8), .DEPTH(4), .BYPASS(1), .AF_LEVEL(3)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_bus.slave)
  );

  inbuf_fifo_if #(.W(8), .DEPTH(4)) c_bus ();
  inbuf_fifo #(.W(8), .DEPTH(4), .BYPASS(0), .AF_LEVEL(3)) u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (c_bus.slave)
  );

  logic [8:0] qa[$];
  logic [8:0] qc[$];
  int a_pops = 0;
  int c_pops = 0;

  // Monitor A: every token the core takes must be the next expected one.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && a_bus.core_data[8] && !a_bus.core_stop) begin
      a_pops++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_spurious: got 0x%0h, expected no token", a_bus.core_data);
      end else begin
        check("a_order", 32'(a_bus.core_data), 32'(qa.pop_front()));
      end
    end
  end

  // Monitor C
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && c_bus.core_data[8] && !c_bus.core_stop) begin
      c_pops++;
      if (qc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c_spurious: got 0x%0h, expected no token", c_bus.core_data);
      end else begin
        check("c_order", 32'(c_bus.core_data), 32'(qc.pop_front()));
      end
    end
  end

  task automatic a_send(input logic [8:0] tok);
    int n;
    n = 0;
    @(negedge clk);
    a_bus.in_data = tok;
    #1;
    while (a_bus.back_stop && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("a_send_accept", 32'(a_bus.back_stop), 0);
    qa.push_back(tok);
    @(posedge clk);
    #1;
    a_bus.in_data = '0;
  endtask

  task automatic c_send(input logic [8:0] tok);
    int n;
    n = 0;
    @(negedge clk);
    c_bus.in_data = tok;
    #1;
    while (c_bus.back_stop && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("c_send_accept", 32'(c_bus.back_stop), 0);
    qc.push_back(tok);
    @(posedge clk);
    #1;
    c_bus.in_data = '0;
  endtask

  // Random instances: DEPTH in {1,2,3,5}, both bypass settings
  logic [7:0] rnd_done;

  for (genvar g = 0; g < 8; g++) begin : g_rnd
    localparam int D = (g / 2 == 3) ? 5 : g / 2 + 1;
    localparam int B = g % 2;

    inbuf_fifo_if #(.W(8), .DEPTH(D)) bus ();
    inbuf_fifo #(.W(8), .DEPTH(D), .BYPASS(B), .AF_LEVEL(D - 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    logic [8:0] q[$];
    logic       done = 1'b0;

    assign rnd_done[g] = done;

    // Upstream + core driver; a valid token is held until accepted.
    initial begin
      logic [8:0] tok;
      bit         hold;
      bus.in_data   = '0;
      bus.core_stop = 1'b0;
      hold          = 1'b0;
      wait (rand_go);
      for (int c = 0; c < RCYC; c++) begin
        @(negedge clk);
        if (!hold) begin
          tok[7:0]    = 8'($urandom);
          tok[8]      = 1'($urandom_range(0, 1));
          bus.in_data = tok;
        end
        bus.core_stop = 1'($urandom_range(0, 1));
        #1;
        if (bus.in_data[8] && !bus.back_stop) begin
          q.push_back(bus.in_data);
          hold = 1'b0;
        end else begin
          hold = bus.in_data[8];
        end
      end
      @(negedge clk);
      bus.in_data   = '0;
      bus.core_stop = 1'b0;
      repeat (D + 3) @(negedge clk);
      #3;
      check($sformatf("rnd%0d_drained", g), 32'(q.size()), 0);
      check($sformatf("rnd%0d_count_zero", g), 32'(bus.count), 0);
      done = 1'b1;
    end

    initial forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.core_data[8] && !bus.core_stop) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd%0d_spurious: got 0x%0h, expected no token", g, bus.core_data);
        end else begin
          check($sformatf("rnd%0d_order", g), 32'(bus.core_data), 32'(q.pop_front()));
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int pops0;
    int max_cnt;
    a_bus.in_data   = '0;
    a_bus.core_stop = 1'b0;
    c_bus.in_data   = '0;
    c_bus.core_stop = 1'b0;

    #8;
    check("a_rst_count", 32'(a_bus.count), 0);
    check("a_rst_back_stop", 32'(a_bus.back_stop), 0);
    check("a_rst_almost_full", 32'(a_bus.almost_full), 0);
    check("a_rst_valid", 32'(a_bus.core_data[8]), 0);
    check("c_rst_core_data", 32'(c_bus.core_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream with three tokens stored
    a_bus.core_stop = 1'b1;
    a_send(9'h101);
    a_send(9'h102);
    a_send(9'h103);
    check("a_pre_reset_count", 32'(a_bus.count), 3);
    check("a_pre_reset_head", 32'(a_bus.core_data), 32'h101);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_async_rst_count", 32'(a_bus.count), 0);
    check("a_async_rst_back_stop", 32'(a_bus.back_stop), 0);
    check("a_async_rst_valid", 32'(a_bus.core_data[8]), 0);
    check("a_async_rst_almost_full", 32'(a_bus.almost_full), 0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // First token after reset passes straight through
    a_bus.core_stop = 1'b0;
    @(negedge clk);
    a_bus.in_data = 9'h1AA;
    #1;
    check("a_bypass_same_cycle", 32'(a_bus.core_data), 32'h1AA);
    qa.push_back(9'h1AA);
    @(posedge clk);
    #1;
    a_bus.in_data = '0;
    check("a_bypass_not_stored", 32'(a_bus.count), 0);

    // Fill to full with the core stalled
    a_bus.core_stop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_send(9'h100 + 9'(i));
      check("a_fill_count", 32'(a_bus.count), 32'(i));
      check("a_fill_almost_full", 32'(a_bus.almost_full), 32'(i >= 3));
      check("a_fill_back_stop", 32'(a_bus.back_stop), 32'(i == 4));
    end

    // Fifth token is held upstream while full
    @(negedge clk);
    a_bus.in_data = 9'h105;
    #1;
    check("a_full_hold_bs", 32'(a_bus.back_stop), 1);
    check("a_full_hold_count", 32'(a_bus.count), 4);
    @(negedge clk);
    #1;
    check("a_full_hold2_count", 32'(a_bus.count), 4);

    // Drain: back_stop drops one cycle after the first pop
    @(negedge clk);
    a_bus.core_stop = 1'b0;
    pops0 = a_pops;
    #1;
    check("a_bs_same_cycle", 32'(a_bus.back_stop), 1);
    @(negedge clk);
    #1;
    check("a_bs_next_cycle", 32'(a_bus.back_stop), 0);
    check("a_count_after_pop", 32'(a_bus.count), 3);
    qa.push_back(9'h105);
    @(posedge clk);
    #1;
    a_bus.in_data = '0;
    repeat (4) @(negedge clk);
    #1;
    check("a_drain_pops", 32'(a_pops - pops0), 5);
    check("a_drain_count", 32'(a_bus.count), 0);

    // Simultaneous push/pop at count=2 across the write-pointer wrap
    a_bus.core_stop = 1'b1;
    a_send(9'h120);
    a_send(9'h121);
    check("a_wrap_pre_count", 32'(a_bus.count), 2);
    check("a_wrap_pre_wr_ptr", 32'(u_a.wr_ptr_q), 3);
    a_bus.core_stop = 1'b0;
    a_send(9'h122);
    check("a_simul_count", 32'(a_bus.count), 2);
    check("a_simul_wr_ptr_wrap", 32'(u_a.wr_ptr_q), 0);
    a_send(9'h123);
    check("a_simul2_count", 32'(a_bus.count), 2);
    repeat (3) @(negedge clk);
    #3;
    check("a_wrap_drain_count", 32'(a_bus.count), 0);
    check("a_wrap_drain_queue", 32'(qa.size()), 0);

    // Registered mode: one cycle of latency from an empty buffer
    @(negedge clk);
    c_bus.in_data = 9'h155;
    #1;
    check("c_same_cycle_invalid", 32'(c_bus.core_data[8]), 0);
    check("c_same_cycle_count", 32'(c_bus.count), 0);
    qc.push_back(9'h155);
    @(posedge clk);
    #1;
    c_bus.in_data = '0;
    check("c_latency1_data", 32'(c_bus.core_data), 32'h155);
    check("c_latency1_count", 32'(c_bus.count), 1);
    @(posedge clk);
    #1;
    check("c_popped_count", 32'(c_bus.count), 0);

    // Streaming 100 tokens: occupancy never exceeds one, one pop per cycle
    @(negedge clk);
    pops0   = c_pops;
    max_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      c_send({1'b1, 8'($urandom)});
      if (int'(c_bus.count) > max_cnt) max_cnt = int'(c_bus.count);
    end
    @(negedge clk);
    #3;
    check("c_stream_max_count", 32'(max_cnt), 1);
    check("c_stream_pops", 32'(c_pops - pops0), 100);
    @(posedge clk);
    #1;
    check("c_stream_final_count", 32'(c_bus.count), 0);
    check("c_stream_queue", 32'(qc.size()), 0);

    // Random traffic on the remaining instances
    rand_go = 1'b1;
    for (int n = 0; n < RCYC + 200 && !(&rnd_done); n++) @(negedge clk);
    check("rnd_all_done", 32'(&rnd_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
